// File: rtl/instr_fetch.sv
// instr_fetch: PC / fetch stage in front of the instruction ROM.
// Owns the program counter, registers the ROM word into the instruction
// register (IR) and hands it to decode with a valid/ready handshake. Handles
// the reset vector, branch/JMP redirects, and the ILLOP trap (decode-reported
// illegal opcode or a fetch beyond the ROM).
//
// Optional interrupt vector (XADR): define INSTR_FETCH_IRQ_EN to add the irq
// input and in_isr output.
//
// Ports:
//   clk, rst_n          clock (rising edge), async active-low reset
//   pc                  ROM byte address (word aligned)
//   id                  ROM instruction word for pc (combinational)
//   ir, ir_pc, ir_pc4   registered instruction, its address, address + 4
//   ir_valid, ir_ready  IR handshake with decode
//   redirect, redirect_pc  taken branch/JMP from decode
//   illop_in            decode reports an illegal opcode
//   illop               one-cycle pulse when the ILLOP vector is taken
//   xp                  saved return address for trap/interrupt
//   irq, in_isr         (INSTR_FETCH_IRQ_EN) interrupt request / in handler
module instr_fetch #(
  parameter logic [31:0] RESET_ADDR = 32'd0,
  parameter logic [31:0] ILLOP_ADDR = 32'd4,
  parameter logic [31:0] XADR_ADDR  = 32'd8,
  parameter logic [31:0] ADDR_LIMIT = 32'd512
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [31:0] pc,
  input  logic [31:0] id,
  output logic [31:0] ir,
  output logic [31:0] ir_pc,
  output logic [31:0] ir_pc4,
  output logic        ir_valid,
  input  logic        ir_ready,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  input  logic        illop_in,
  output logic        illop,
`ifdef INSTR_FETCH_IRQ_EN
  input  logic        irq,
  output logic        in_isr,
`endif
  output logic [31:0] xp
);

  localparam int unsigned XLEN = 32;

  // HOLD records that the IR was stalled on the previous edge; the live
  // stall decision always comes from the current ir_valid/ir_ready.
  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [XLEN-1:0]   pc_d, ir_d, ir_pc_d, ir_pc4_d, xp_d;
  logic              ir_valid_d, illop_d;
  logic              live_c, stall_c, fetch_ok_c, oor_c, take_illop_c;
  logic [XLEN-1:0]   target_c;
`ifdef INSTR_FETCH_IRQ_EN
  logic              in_isr_d;
  logic              take_irq_c;
`endif

  // Low address bits of the redirect target are intentionally dropped.
  logic unused_c;
`ifdef INSTR_FETCH_IRQ_EN
  assign unused_c = ^redirect_pc[1:0];
`else
  assign unused_c = ^{redirect_pc[1:0], XADR_ADDR};
`endif

  // Redirect/trap qualification for the current cycle.
  always_comb begin
    live_c       = (state_q != BOOT);
    stall_c      = ir_valid & ~ir_ready;
    fetch_ok_c   = live_c & ~stall_c;
    oor_c        = fetch_ok_c & (pc >= ADDR_LIMIT);
    take_illop_c = live_c & (illop_in | oor_c);
    target_c     = {redirect_pc[XLEN-1:2], 2'b00};
`ifdef INSTR_FETCH_IRQ_EN
    take_irq_c   = live_c & irq & ~in_isr & ir_valid & ir_ready & ~take_illop_c;
`endif
  end

  // Next-state and next-output logic.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc;
    ir_d       = ir;
    ir_pc_d    = ir_pc;
    ir_pc4_d   = ir_pc4;
    ir_valid_d = ir_valid;
    illop_d    = 1'b0;
    xp_d       = xp;
`ifdef INSTR_FETCH_IRQ_EN
    in_isr_d   = in_isr;
`endif

    case (state_q)
      BOOT:    state_d = RUN;
      RUN,
      HOLD:    state_d = stall_c ? HOLD : RUN;
      default: state_d = BOOT;
    endcase

    // Every vector change discards this cycle's id word, leaving one bubble.
    if (take_illop_c) begin
      pc_d       = ILLOP_ADDR;
      xp_d       = illop_in ? ir_pc4 : pc;
      illop_d    = 1'b1;
      ir_valid_d = 1'b0;
    end
`ifdef INSTR_FETCH_IRQ_EN
    else if (take_irq_c) begin
      pc_d       = XADR_ADDR;
      xp_d       = pc;
      in_isr_d   = 1'b1;
      ir_valid_d = 1'b0;
    end
`endif
    else if (live_c && redirect) begin
      pc_d       = target_c;
      ir_valid_d = 1'b0;
`ifdef INSTR_FETCH_IRQ_EN
      // Returning to the saved point ends the interrupt handler.
      if (target_c == xp) begin
        in_isr_d = 1'b0;
      end
`endif
    end else if (fetch_ok_c) begin
      ir_d       = id;
      ir_pc_d    = pc;
      ir_pc4_d   = XLEN'(pc + 32'd4);
      ir_valid_d = 1'b1;
      pc_d       = XLEN'(pc + 32'd4);
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= BOOT;
      pc       <= RESET_ADDR;
      ir       <= '0;
      ir_pc    <= '0;
      ir_pc4   <= 32'd4;
      ir_valid <= 1'b0;
      illop    <= 1'b0;
      xp       <= '0;
`ifdef INSTR_FETCH_IRQ_EN
      in_isr   <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      pc       <= pc_d;
      ir       <= ir_d;
      ir_pc    <= ir_pc_d;
      ir_pc4   <= ir_pc4_d;
      ir_valid <= ir_valid_d;
      illop    <= illop_d;
      xp       <= xp_d;
`ifdef INSTR_FETCH_IRQ_EN
      in_isr   <= in_isr_d;
`endif
    end
  end

endmodule

// File: tb/tb_instr_fetch.sv
// Directed testbench for instr_fetch with a behavioural ROM.
module tb_instr_fetch;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] pc, id, ir, ir_pc, ir_pc4, xp, redirect_pc;
  logic        ir_valid, ir_ready, redirect, illop_in, illop;
`ifdef INSTR_FETCH_IRQ_EN
  logic        irq, in_isr;
`endif

  int checks = 0;
  int passed = 0;

  always #5 clk = ~clk;

  // ROM: word 0 is a marker, every other word is 0xC0DE0000 | address.
  function automatic logic [31:0] rom_word(input logic [31:0] a);
    return (a == 32'd0) ? 32'h7000_0001 : (32'hC0DE_0000 | a);
  endfunction
  assign id = rom_word(pc);

  instr_fetch dut (
    .clk(clk), .rst_n(rst_n), .pc(pc), .id(id), .ir(ir), .ir_pc(ir_pc),
    .ir_pc4(ir_pc4), .ir_valid(ir_valid), .ir_ready(ir_ready),
    .redirect(redirect), .redirect_pc(redirect_pc), .illop_in(illop_in),
    .illop(illop),
`ifdef INSTR_FETCH_IRQ_EN
    .irq(irq), .in_isr(in_isr),
`endif
    .xp(xp)
  );

  // redirect and illop_in may only accompany an IR transfer.
  assert property (@(posedge clk) disable iff (!rst_n)
                   (redirect || illop_in) |-> (ir_valid && ir_ready))
    else $error("FAIL handshake_assert redirect/illop_in without transfer");

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b1; ir_ready = 1'b1; redirect = 1'b0; redirect_pc = '0; illop_in = 1'b0;
`ifdef INSTR_FETCH_IRQ_EN
    irq = 1'b0;
`endif
    #1 rst_n = 1'b0;
    #1;
    checks++; if ({pc, ir, ir_pc} !== 96'd0) $display("FAIL reset_pc_ir got pc=%h ir=%h ir_pc=%h exp 0", pc, ir, ir_pc); else passed++;
    checks++; if ({ir_pc4, xp, ir_valid, illop} !== {32'd4, 32'd0, 2'b00}) $display("FAIL reset_misc got ir_pc4=%h xp=%h v=%b illop=%b exp 4/0/0/0", ir_pc4, xp, ir_valid, illop); else passed++;
    step();
    rst_n = 1'b1;
    step();
    checks++; if ({ir_valid, pc} !== {1'b0, 32'd0}) $display("FAIL boot_bubble got v=%b pc=%h exp v=0 pc=0", ir_valid, pc); else passed++;
    step();
    checks++; if ({ir_valid, ir, ir_pc, ir_pc4} !== {1'b1, 32'h7000_0001, 32'd0, 32'd4}) $display("FAIL first_word got v=%b ir=%h pc=%h pc4=%h exp 1/70000001/0/4", ir_valid, ir, ir_pc, ir_pc4); else passed++;
  endtask

  task automatic test_stream();
    step();
    checks++; if ({ir_valid, ir, ir_pc} !== {1'b1, 32'hC0DE_0004, 32'd4}) $display("FAIL stream_4 got v=%b ir=%h ir_pc=%h exp 1/c0de0004/4", ir_valid, ir, ir_pc); else passed++;
    step();
    checks++; if ({ir_valid, ir, ir_pc, pc} !== {1'b1, 32'hC0DE_0008, 32'd8, 32'd12}) $display("FAIL stream_8 got v=%b ir=%h ir_pc=%h pc=%h exp 1/c0de0008/8/c", ir_valid, ir, ir_pc, pc); else passed++;
  endtask

  task automatic test_hold();
    ir_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step();
      checks++; if ({ir_valid, ir, ir_pc, pc} !== {1'b1, 32'hC0DE_0008, 32'd8, 32'd12}) $display("FAIL hold_%0d got v=%b ir=%h ir_pc=%h pc=%h exp 1/c0de0008/8/c", k, ir_valid, ir, ir_pc, pc); else passed++;
    end
    ir_ready = 1'b1;
    step();
    checks++; if ({ir_valid, ir_pc, pc} !== {1'b1, 32'd12, 32'd16}) $display("FAIL hold_release got v=%b ir_pc=%h pc=%h exp 1/c/10", ir_valid, ir_pc, pc); else passed++;
    step();
    checks++; if ({ir_valid, ir_pc, ir_pc4} !== {1'b1, 32'd16, 32'd20}) $display("FAIL after_hold got v=%b ir_pc=%h pc4=%h exp 1/10/14", ir_valid, ir_pc, ir_pc4); else passed++;
  endtask

  task automatic test_redirect();
    redirect = 1'b1; redirect_pc = 32'h53;
    step();
    redirect = 1'b0;
    checks++; if ({ir_valid, pc} !== {1'b0, 32'h50}) $display("FAIL redir_bubble got v=%b pc=%h exp 0/50", ir_valid, pc); else passed++;
    step();
    checks++; if ({ir_valid, ir, ir_pc, ir_pc4, pc} !== {1'b1, 32'hC0DE_0050, 32'h50, 32'h54, 32'h54}) $display("FAIL redir_target got v=%b ir=%h ir_pc=%h pc4=%h pc=%h exp 1/c0de0050/50/54/54", ir_valid, ir, ir_pc, ir_pc4, pc); else passed++;
  endtask

  task automatic test_limit();
    redirect = 1'b1; redirect_pc = 32'd500;
    step();
    redirect = 1'b0;
    step();
    checks++; if ({ir_valid, ir_pc} !== {1'b1, 32'd500}) $display("FAIL lim_500 got v=%b ir_pc=%0d exp 1/500", ir_valid, ir_pc); else passed++;
    step();
    step();
    checks++; if ({ir_valid, ir_pc, pc, illop} !== {1'b1, 32'd508, 32'd512, 1'b0}) $display("FAIL lim_508 got v=%b ir_pc=%0d pc=%0d illop=%b exp 1/508/512/0", ir_valid, ir_pc, pc, illop); else passed++;
    step();
    checks++; if ({ir_valid, illop, xp, pc} !== {1'b0, 1'b1, 32'd512, 32'd4}) $display("FAIL lim_trap got v=%b illop=%b xp=%0d pc=%0d exp 0/1/512/4", ir_valid, illop, xp, pc); else passed++;
    step();
    checks++; if ({ir_valid, illop, ir_pc, ir} !== {1'b1, 1'b0, 32'd4, 32'hC0DE_0004}) $display("FAIL lim_vector got v=%b illop=%b ir_pc=%0d ir=%h exp 1/0/4/c0de0004", ir_valid, illop, ir_pc, ir); else passed++;
  endtask

  task automatic test_illop_in();
    redirect = 1'b1; redirect_pc = 32'd200;
    step();
    redirect = 1'b0;
    step();
    checks++; if ({ir_valid, ir_pc, ir_pc4} !== {1'b1, 32'd200, 32'd204}) $display("FAIL ill_200 got v=%b ir_pc=%0d pc4=%0d exp 1/200/204", ir_valid, ir_pc, ir_pc4); else passed++;
    illop_in = 1'b1;
    step();
    illop_in = 1'b0;
    checks++; if ({ir_valid, illop, xp, pc} !== {1'b0, 1'b1, 32'd204, 32'd4}) $display("FAIL ill_trap got v=%b illop=%b xp=%0d pc=%0d exp 0/1/204/4", ir_valid, illop, xp, pc); else passed++;
    step();
    checks++; if ({ir_valid, illop, ir_pc} !== {1'b1, 1'b0, 32'd4}) $display("FAIL ill_vector got v=%b illop=%b ir_pc=%0d exp 1/0/4", ir_valid, illop, ir_pc); else passed++;
  endtask

  task automatic test_reset_in_hold();
    ir_ready = 1'b0;
    step();
    checks++; if ({ir_valid, ir_pc, pc} !== {1'b1, 32'd4, 32'd8}) $display("FAIL rh_hold got v=%b ir_pc=%0d pc=%0d exp 1/4/8", ir_valid, ir_pc, pc); else passed++;
    #2 rst_n = 1'b0;
    #1;
    checks++; if ({ir_valid, pc, ir, ir_pc, ir_pc4, xp} !== {1'b0, 32'd0, 32'd0, 32'd0, 32'd4, 32'd0}) $display("FAIL rh_reset got v=%b pc=%h ir=%h ir_pc=%h pc4=%h xp=%h exp 0/0/0/0/4/0", ir_valid, pc, ir, ir_pc, ir_pc4, xp); else passed++;
    rst_n = 1'b1; ir_ready = 1'b1;
    step();
    checks++; if (ir_valid !== 1'b0) $display("FAIL rh_boot got v=%b exp 0", ir_valid); else passed++;
    step();
    checks++; if ({ir_valid, ir, ir_pc} !== {1'b1, 32'h7000_0001, 32'd0}) $display("FAIL rh_restart got v=%b ir=%h ir_pc=%h exp 1/70000001/0", ir_valid, ir, ir_pc); else passed++;
  endtask

  task automatic test_redirect_oor();
    redirect = 1'b1; redirect_pc = 32'h300;
    step();
    redirect = 1'b0;
    checks++; if ({ir_valid, pc} !== {1'b0, 32'h300}) $display("FAIL oor_bubble got v=%b pc=%h exp 0/300", ir_valid, pc); else passed++;
    step();
    checks++; if ({ir_valid, illop, xp, pc} !== {1'b0, 1'b1, 32'h300, 32'd4}) $display("FAIL oor_trap got v=%b illop=%b xp=%h pc=%h exp 0/1/300/4", ir_valid, illop, xp, pc); else passed++;
    step();
    checks++; if ({ir_valid, ir_pc, illop} !== {1'b1, 32'd4, 1'b0}) $display("FAIL oor_vector got v=%b ir_pc=%h illop=%b exp 1/4/0", ir_valid, ir_pc, illop); else passed++;
  endtask

`ifdef INSTR_FETCH_IRQ_EN
  task automatic test_irq();
    redirect = 1'b1; redirect_pc = 32'd80;
    step();
    redirect = 1'b0;
    step();
    checks++; if ({ir_valid, ir_pc, in_isr} !== {1'b1, 32'd80, 1'b0}) $display("FAIL irq_80 got v=%b ir_pc=%0d isr=%b exp 1/80/0", ir_valid, ir_pc, in_isr); else passed++;
    irq = 1'b1;
    step();
    irq = 1'b0;
    checks++; if ({ir_valid, in_isr, xp, pc} !== {1'b0, 1'b1, 32'd84, 32'd8}) $display("FAIL irq_take got v=%b isr=%b xp=%0d pc=%0d exp 0/1/84/8", ir_valid, in_isr, xp, pc); else passed++;
    step();
    checks++; if ({ir_valid, ir_pc} !== {1'b1, 32'd8}) $display("FAIL irq_vector got v=%b ir_pc=%0d exp 1/8", ir_valid, ir_pc); else passed++;
    redirect = 1'b1; redirect_pc = 32'd84;
    step();
    redirect = 1'b0;
    checks++; if ({ir_valid, in_isr} !== {1'b0, 1'b0}) $display("FAIL irq_return got v=%b isr=%b exp 0/0", ir_valid, in_isr); else passed++;
    step();
    checks++; if ({ir_valid, ir_pc} !== {1'b1, 32'd84}) $display("FAIL irq_resume got v=%b ir_pc=%0d exp 1/84", ir_valid, ir_pc); else passed++;
  endtask
`endif

  initial begin
    #20000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_stream();
    test_hold();
    test_redirect();
    test_limit();
    test_illop_in();
    test_reset_in_hold();
    test_redirect_oor();
`ifdef INSTR_FETCH_IRQ_EN
    test_irq();
`endif
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/instr_fetch.md
Name: instr_fetch

Overview:
- PC/fetch stage directly upstream of the instruction ROM.
- Owns the program counter and drives the ROM's word address.
- Registers the returned instruction word into an instruction register (IR) with a valid/ready handshake to the decode stage.
- Handles branch/JMP redirects, reset vector, out-of-range fetch trap (ILLOP) and, optionally, the interrupt vector (XADR).

Parameters:
- RESET_ADDR, 32'd0, PC loaded on reset.
- ILLOP_ADDR, 32'd4, target on out-of-range fetch or illop_i.
- XADR_ADDR, 32'd8, interrupt target (optional feature only).
- ADDR_LIMIT, 32'd512, first byte address outside the ROM (128 words × 4).

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- pc  out  32  byte address to ROM, bits[1:0] always 0
- id  in  32  combinational instruction word from ROM for pc
- ir  out  32  registered instruction to decode
- ir_pc  out  32  address of instruction in ir
- ir_pc4  out  32  ir_pc + 4, for branch offset and linkage
- ir_valid  out  1  ir holds a live instruction
- ir_ready  in  1  decode accepts ir this cycle
- redirect  in  1  decode-issued branch/JMP taken
- redirect_pc  in  32  redirect target; bits[1:0] ignored
- illop_in  in  1  decode reports illegal opcode
- illop  out  1  one-cycle pulse when an ILLOP vector is taken
- xp  out  32  saved return address (ir_pc4 of the trapped/interrupted point)

Behaviour:
- Reset (async, rst_n=0):
  - pc=RESET_ADDR; ir=0; ir_pc=0; ir_pc4=4; ir_valid=0; illop=0; xp=0.
  - State=BOOT.
- States:
  - BOOT: one cycle, no capture; then RUN.
  - RUN: normal fetch.
  - HOLD: ir_valid=1 and ir_ready=0.
- Handshake:
  - Transfer when ir_valid & ir_ready.
  - When ir_valid & !ir_ready: pc, ir, ir_pc and ir_pc4 hold (HOLD). ir stays stable and ir_valid stays high until accepted.
- RUN capture (no redirect):
  - ir<=id; ir_pc<=pc; ir_pc4<=pc+4; ir_valid<=1; pc<=pc+4.
  - Zero-bubble throughput: one instruction per cycle while ir_ready=1.
- Redirect priority, highest first (evaluated every cycle, including HOLD):
  1. illop_in or out-of-range fetch.
     - Out-of-range means pc ≥ ADDR_LIMIT while in RUN.
     - Action: pc<=ILLOP_ADDR; xp<=ir_pc4 (illop_in) or pc (out-of-range); illop<=1 for one cycle.
  2. redirect.
     - Action: pc<={redirect_pc[31:2],2'b00}.
  3. Sequential fetch.
- On any redirect:
  - The word on id that cycle is wrong-path: discard it.
  - ir_valid<=0 next cycle, giving exactly one bubble.
  - Then the target instruction is captured.
- redirect and illop_in are asserted only with ir_valid & ir_ready (decode consumed the branch). The bench checks this as an assertion.
- Arithmetic: pc+4 is mod 2^32. A wrap 0xFFFFFFFC→0 is unreachable because ADDR_LIMIT traps first.
- redirect to an address ≥ ADDR_LIMIT: accepted. The next cycle traps to ILLOP_ADDR and the out-of-range word is never made valid.
- Reset mid-HOLD or mid-redirect: all state is discarded immediately; restarts in BOOT.

Optional Feature:
- Macro: INSTR_FETCH_IRQ_EN.
- With the macro defined:
  - Adds input irq (1 bit, level).
  - Adds output in_isr (1 bit, reset 0).
  - When irq=1, in_isr=0, and a transfer occurs with no higher-priority redirect, the fetch takes the XADR path:
    - pc<=XADR_ADDR; xp<=pc (first un-issued instruction); in_isr<=1; one bubble.
  - in_isr clears on a redirect whose target equals xp (return from interrupt).
  - Priority: illop > irq > redirect.
- Without the macro: irq and in_isr are absent and XADR_ADDR is unused.

Test Plan:
- Release reset with ROM word0=0x7000_0001, ir_ready=1 → BOOT cycle, ir_valid=0 → then ir=0x7000_0001, ir_pc=0, ir_pc4=4. Next cycles: ir_pc=4, 8, 12 with no gaps.
- ir_ready held 0 for 3 cycles with ir_pc=8 → ir, ir_pc and pc all stable for 3 cycles. When ir_ready returns to 1, ir_pc=12 follows with no loss or duplication.
- redirect=1, redirect_pc=0x53 on the transfer of ir_pc=16 → next cycle ir_valid=0 → then ir_pc=0x50 and pc=0x54.
- Sequential run to pc=508 → ir_pc=508 delivered, then illop pulses once, xp=512, one bubble, ir_pc=4.
- illop_in=1 at ir_pc=200 → xp=204, ir_pc=4 after one bubble. rst_n pulsed low while in HOLD → outputs at reset values immediately; restart delivers ir_pc=0.
- (INSTR_FETCH_IRQ_EN) irq=1 while ir_pc=80 is transferred → xp=84, in_isr=1, ir_pc=8 after one bubble. Then redirect to 84 → in_isr=0 and ir_pc=84.
